// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with start/busy/done handshake, flush abort and divide fast paths
module muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_operand1,
    input  logic [XLEN-1:0] i_operand2,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic              r_neg, r_rneg;
    logic [XLEN-1:0]   r_m, r_result;
    logic [2*XLEN-1:0] r_acc, w_step, w_prod;
    logic              w_accept, w_is_div, w_a_neg, w_b_neg, w_div0, w_ovf, w_fast, w_last;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_fast_res, w_fix_res, w_q, w_r;

    // Multiply: LSB-first shift-add with the multiplier in the low half.
    // Divide: restoring division with remainder in the high half, quotient shifting into the low half.
    function automatic logic [2*XLEN-1:0] f_step(input logic [2*XLEN-1:0] acc, input logic [XLEN-1:0] m,
                                                 input logic is_div);
        logic [XLEN:0] t;
        logic          ge;
        for (int k = 0; k < UNROLL; k++) begin
            if (is_div) begin
                t   = acc[2*XLEN-1:XLEN-1];
                ge  = t >= {1'b0, m};
                t   = ge ? t - {1'b0, m} : t;
                acc = {t[XLEN-1:0], acc[XLEN-2:0], ge};
            end else begin
                t   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
                acc = {t, acc[XLEN-1:1]};
            end
        end
        return acc;
    endfunction

    assign w_accept   = i_start & ~i_flush & (r_state == S_IDLE || r_state == S_DONE);
    assign w_is_div   = i_funct3[2];
    assign w_a_neg    = i_operand1[XLEN-1] & (i_funct3 == 3'b001 || i_funct3 == 3'b010 ||
                                              i_funct3 == 3'b100 || i_funct3 == 3'b110);
    assign w_b_neg    = i_operand2[XLEN-1] & (i_funct3 == 3'b001 || i_funct3 == 3'b100 || i_funct3 == 3'b110);
    assign w_a_mag    = w_a_neg ? -i_operand1 : i_operand1;
    assign w_b_mag    = w_b_neg ? -i_operand2 : i_operand2;
    assign w_div0     = w_is_div & (i_operand2 == '0);
    assign w_ovf      = w_is_div & ~i_funct3[0] & (i_operand1 == {1'b1, {(XLEN-1){1'b0}}}) & (&i_operand2);
    assign w_fast     = w_div0 | w_ovf;
    assign w_fast_res = w_div0 ? (i_funct3[1] ? i_operand1 : '1) : (i_funct3[1] ? '0 : i_operand1);
    assign w_last     = r_cnt == CW'(N - 1);
    assign w_step     = f_step(r_acc, r_m, r_op[2]);
    assign w_prod     = r_neg ? -r_acc : r_acc;
    assign w_q        = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_r        = r_rneg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    assign w_fix_res  = r_op[2] ? (r_op[1] ? w_r : w_q) :
                        (r_op[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
    assign o_result   = r_result;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state: accept from IDLE/DONE, iterate N cycles, sign-fix, flush aborts CALC/FIX
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = w_accept ? (w_fast ? S_DONE : S_CALC) : S_IDLE;
            S_CALC:         w_next = i_flush ? S_IDLE : (w_last ? S_FIX : S_CALC);
            default:        w_next = i_flush ? S_IDLE : S_DONE;
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        o_busy = r_state == S_CALC || r_state == S_FIX;
        o_done = r_state == S_DONE;
    end

    // Datapath: latch prepared operands on accept, iterate in CALC, write result on fast path or FIX
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_m      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_cnt  <= '0;
                r_op   <= i_funct3;
                r_neg  <= w_a_neg ^ w_b_neg;
                r_rneg <= w_a_neg;
                r_m    <= w_is_div ? w_b_mag : w_a_mag;
                r_acc  <= {{XLEN{1'b0}}, w_is_div ? w_a_mag : w_b_mag};
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_step;
            end
            if (w_accept && w_fast)
                r_result <= w_fast_res;
            else if (r_state == S_FIX && !i_flush)
                r_result <= w_fix_res;
        end
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit implementing the RV32M `funct3` operation set for the execute stage of the pipelined CPU. It replaces single-cycle M-extension arithmetic with a multi-cycle datapath whose radix is selected at build time. It exposes a start/busy/done handshake so the pipeline control can stall while an operation is in flight. It supports an abort on branch flush and single-cycle fast paths for the divide corner cases.

## Interface
- `XLEN`, default 32: operand and result width; must be even and ≥ 8.
- `UNROLL`, default 1: bits retired per iteration cycle; legal values are 1, 2 and 4; `XLEN % UNROLL == 0`.
- `CLK`  in  1: clock; all state is updated on the rising edge.
- `RESET`  in  1: asynchronous, active-high reset.
- `START`  in  1: request a new operation; sampled on the rising edge.
- `FUNCT3`  in  3: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `OPERAND1`  in  XLEN: rs1 value (multiplicand or dividend).
- `OPERAND2`  in  XLEN: rs2 value (multiplier or divisor).
- `FLUSH`  in  1: synchronous abort of the current operation.
- `BUSY`  out  1: an operation is in flight; the pipeline stalls while this is high.
- `DONE`  out  1: one-cycle pulse; `RESULT` is valid in this cycle.
- `RESULT`  out  XLEN: registered result; held until the next completion.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- **Reset:** asserting `RESET` forces the state to IDLE and clears the counter, `BUSY`, `DONE` and `RESULT` to 0 immediately. This holds mid-operation; the in-flight operation is lost.
- **Accepting a request:** `START` is accepted only in IDLE or DONE.
  - On acceptance, `OPERAND1`, `OPERAND2` and `FUNCT3` are latched. Later changes on the inputs are ignored.
  - `START` in CALC or FIX is ignored.
- **Operand preparation (IDLE/DONE → CALC):**
  - Signed operands are converted to magnitudes, and the result-sign flags are recorded.
  - MULHSU treats `OPERAND1` as signed and `OPERAND2` as unsigned.
- **CALC:**
  - Multiply: shift-add; each cycle adds `UNROLL` partial products into a 2·XLEN accumulator.
  - Divide: restoring division, `UNROLL` quotient bits per cycle.
  - The counter runs for N = XLEN/UNROLL cycles, then the FSM moves to FIX.
- **FIX:** applies two's-complement sign correction.
  - MUL returns the low XLEN bits of the product; MULH, MULHSU and MULHU return the high XLEN bits.
  - The quotient takes the sign XOR of the operands. The remainder takes the dividend's sign.
  - The corrected value is written to `RESULT` and the FSM enters DONE.
- **Fast paths (IDLE/DONE → DONE directly, skipping CALC and FIX):**
  - Divisor zero: DIV and DIVU return all-ones; REM and REMU return the dividend.
  - Signed overflow (dividend = most negative value, divisor = −1): DIV returns the dividend; REM returns 0.
- **DONE:** `DONE` is high for this one cycle.
  - With no `START`, the FSM returns to IDLE.
  - With `START`, a new operation is accepted back-to-back.
- **FLUSH:** in CALC or FIX, the FSM goes to IDLE on the next edge. No `DONE` is generated and `RESULT` is unchanged.
  - `FLUSH` and `START` in the same cycle: `FLUSH` wins and `START` is dropped.
  - `FLUSH` in IDLE or DONE has no effect other than dropping a coincident `START`.

## Timing
- `START` sampled at edge 0.
  - `BUSY` is high from edge 0.
  - CALC occupies edges 1..N; FIX ends at edge N+1.
  - `DONE`/`RESULT` are valid after edge N+1. `BUSY` falls on that same edge.
- Total latency is N+1 cycles: 33 for XLEN=32, UNROLL=1; 9 for UNROLL=4.
- Fast path: `DONE` is high after edge 0 (latency 1). `BUSY` stays low throughout.
- `BUSY` and `DONE` are never high in the same cycle.
- All outputs are registered; there are no combinational input-to-output paths.
- Throughput: one operation per N+1 cycles, with back-to-back issue from DONE.

## Test plan
- **Multiply, XLEN=32, UNROLL=1:**
  - MUL 7×0xFFFFFFFD → 0xFFFFFFEB.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - Each asserts `DONE` exactly 33 cycles after `START`.
- **Signed divide and remainder:**
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- **Fast paths:**
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
  - Each asserts `DONE` one cycle after `START`, with `BUSY` never high.
- **Control:**
  - `FLUSH` in cycle 10 of a DIV: no `DONE`, `RESULT` keeps its prior value, and `BUSY` is low next cycle.
  - `START` with changed operands during `BUSY` is ignored; the original result is produced.
- **Reset and back-to-back issue:**
  - `RESET` pulsed mid-CALC without a clock edge: `BUSY`, `DONE` and `RESULT` go to 0 immediately.
  - `START` in a DONE cycle is accepted; the second result arrives 33 cycles later.
- **UNROLL=4:** MUL 0x12345678×0x10 → 0x23456780, with `DONE` after 9 cycles. DIVU 0xFFFFFFFF/3 → 0x55555555, with `DONE` after 9 cycles.
